// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between eight clients and rr_arbiter8.
//   req       : 8-bit level request vector, bit i = requester i (clients drive)
//   gnt       : 8-bit one-hot grant, all-zero when idle (arbiter drives)
//   gnt_id    : 3-bit index of the granted requester, 0 when idle
//   gnt_valid : high while any grant is active
//   timeout   : one-cycle pulse when a grant is revoked by the hold limit
// Modports: master = client side, slave = arbiter side.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (output req, input gnt, input gnt_id, input gnt_valid, input timeout);
    modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among 8 requesters,
// with hold/release handshake and an optional hold timeout (MAX_HOLD, 0 = off).
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   arb   : rr_arbiter8_if.slave (req in; gnt, gnt_id, gnt_valid, timeout out)
// All outputs are registered; there is no combinational path from req.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic          clk,
    input logic          rst_n,
    rr_arbiter8_if.slave arb
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    // Hold count value at which the grant has been visible MAX_HOLD cycles.
    localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_e     state_q;
    logic [7:0] gnt_q;
    logic [2:0] gnt_id_q;
    logic       gnt_valid_q;
    logic       timeout_q;
    logic [2:0] last_id_q;
    logic [7:0] hold_cnt_q;

    logic [2:0] win_id_d;
    logic       win_found;
    logic [2:0] cand;

    // Search upward from last_id+1, wrapping 7->0; the 3-bit add wraps naturally.
    always_comb begin
        win_id_d  = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            cand = last_id_q + 3'(k + 1);
            if (!win_found && arb.req[cand]) begin
                win_id_d  = cand;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_id_q   <= 3'd7;
            hold_cnt_q  <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        gnt_q       <= 8'(1) << win_id_d;
                        gnt_id_q    <= win_id_d;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    // Release takes precedence over a coincident timeout.
                    if (!arb.req[gnt_id_q]) begin
                        gnt_q       <= '0;
                        gnt_id_q    <= '0;
                        gnt_valid_q <= 1'b0;
                        last_id_q   <= gnt_id_q;
                        state_q     <= IDLE;
                    end else if (TIMEOUT_EN && hold_cnt_q == HOLD_LAST) begin
                        gnt_q       <= '0;
                        gnt_id_q    <= '0;
                        gnt_valid_q <= 1'b0;
                        last_id_q   <= gnt_id_q;
                        timeout_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_q  <= hold_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_id    = gnt_id_q;
    assign arb.gnt_valid = gnt_valid_q;
    assign arb.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: drives two arbiters (MAX_HOLD 16 and 4) with a shared
// request vector and compares every cycle against a behavioural model.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_drv;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    rr_arbiter8_if if16 ();
    rr_arbiter8_if if4  ();

    assign if16.req = req_drv;
    assign if4.req  = req_drv;

    rr_arbiter8 #(.MAX_HOLD(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .arb(if16));
    rr_arbiter8 #(.MAX_HOLD(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .arb(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: who holds the resource, for how many visible cycles,
    // and who was served last. Index 0 models MAX_HOLD=16, index 1 MAX_HOLD=4.
    int unsigned lim [2] = '{16, 4};
    bit          m_busy [2];
    int unsigned m_id   [2];
    int unsigned m_last [2];
    int unsigned m_held [2];
    bit          m_to   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 0; m_id[d] = 0; m_last[d] = 7; m_held[d] = 0; m_to[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_to[d] = 0;
                if (!m_busy[d]) begin
                    for (int k = 1; k <= 8; k++) begin
                        if (!m_busy[d] && req_drv[(m_last[d] + k) % 8]) begin
                            m_busy[d] = 1;
                            m_id[d]   = (m_last[d] + k) % 8;
                            m_held[d] = 1;
                        end
                    end
                end else if (!req_drv[m_id[d]]) begin
                    m_busy[d] = 0;
                    m_last[d] = m_id[d];
                end else if (lim[d] != 0 && m_held[d] == lim[d]) begin
                    m_busy[d] = 0;
                    m_last[d] = m_id[d];
                    m_to[d]   = 1;
                end else begin
                    m_held[d]++;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("gnt16",   32'(if16.gnt),       m_busy[0] ? (32'd1 << m_id[0]) : 32'd0);
        check_eq("id16",    32'(if16.gnt_id),    m_busy[0] ? m_id[0] : 32'd0);
        check_eq("val16",   32'(if16.gnt_valid), 32'(m_busy[0]));
        check_eq("to16",    32'(if16.timeout),   32'(m_to[0]));
        check_eq("gnt4",    32'(if4.gnt),        m_busy[1] ? (32'd1 << m_id[1]) : 32'd0);
        check_eq("id4",     32'(if4.gnt_id),     m_busy[1] ? m_id[1] : 32'd0);
        check_eq("val4",    32'(if4.gnt_valid),  32'(m_busy[1]));
        check_eq("to4",     32'(if4.timeout),    32'(m_to[1]));
    endtask

    // Drive req at a falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input logic [7:0] r);
        req_drv = r;
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst_n   = 1'b0;
        req_drv = r;
        @(negedge clk);
        check_eq("rst_gnt",   32'(if16.gnt),       32'h0);
        check_eq("rst_val",   32'(if16.gnt_valid), 32'h0);
        check_eq("rst_id",    32'(if4.gnt_id),     32'h0);
        check_eq("rst_to",    32'(if4.timeout),    32'h0);
        rst_n = 1'b1;
    endtask

    logic [7:0] rr;

    initial begin
        rst_n   = 1'b0;
        req_drv = 8'h00;
        #1;
        repeat (2) @(negedge clk);

        // Reset, first grant goes to requester 0, then rotate 0..7,0.
        do_reset(8'hFF);
        step(8'hFF);
        check_eq("first_gnt", 32'(if16.gnt), 32'h01);
        for (int g = 0; g < 9; g++) begin
            check_eq("rot_id", 32'(if16.gnt_id), 32'(g % 8));
            step(8'hFF);
            rr = 8'hFF & ~(8'(1) << (g % 8));
            step(rr);
            check_eq("rot_gap", 32'(if16.gnt_valid), 32'h0);
            step(8'hFF);
        end

        // Wrap and skip from last_id = 5.
        step(8'h00);
        step(8'h20);
        check_eq("ws_5", 32'(if16.gnt), 32'h20);
        step(8'h00);
        step(8'h09);
        check_eq("ws_0", 32'(if16.gnt), 32'h01);
        step(8'h08);
        check_eq("ws_gap", 32'(if16.gnt), 32'h00);
        step(8'h08);
        check_eq("ws_3", 32'(if16.gnt), 32'h08);

        // Hold id 2 for 10 more cycles while requester 6 toggles.
        step(8'h00);
        step(8'h04);
        for (int i = 0; i < 10; i++) begin
            step((i % 2) ? 8'h44 : 8'h04);
            check_eq("hold_gnt", 32'(if16.gnt),     32'h04);
            check_eq("hold_to",  32'(if16.timeout), 32'h0);
        end

        // Timeout with MAX_HOLD=4: 0 and 4 alternate every 5 cycles.
        do_reset(8'h11);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(8'h11);
                check_eq("to_gnt", 32'(if4.gnt), (r % 2) ? 32'h10 : 32'h01);
                check_eq("to_low", 32'(if4.timeout), 32'h0);
            end
            step(8'h11);
            check_eq("to_gap",   32'(if4.gnt),     32'h0);
            check_eq("to_pulse", 32'(if4.timeout), 32'h1);
        end

        // Reset mid-grant clears outputs without a clock edge.
        do_reset(8'h10);
        step(8'h10);
        check_eq("mr_pre", 32'(if16.gnt), 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_gnt", 32'(if16.gnt),       32'h0);
        check_eq("mr_val", 32'(if16.gnt_valid), 32'h0);
        check_eq("mr_id",  32'(if16.gnt_id),    32'h0);
        check_eq("mr_g4",  32'(if4.gnt),        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h10);
        check_eq("mr_post",   32'(if16.gnt),    32'h10);
        check_eq("mr_postid", 32'(if16.gnt_id), 32'h4);

        // Random phase with sticky requests so grants are held for a while.
        rr = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) rr = 8'($urandom);
            step(rr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among 8 requesters and reports the winner both one-hot and as a 3-bit encoded index, the same encoding produced by the team's 8-to-3 encoder. It sits in front of any single-ported datapath shared by eight clients. It adds grant hold and release handshakes and an optional hold timeout, so that no requester can starve the others.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held. 0 disables the timeout. Legal range 0–255.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  8  request vector; bit i is requester i. Level-sensitive.
- `gnt`  output  8  one-hot grant, registered; all-zero when no grant.
- `gnt_id`  output  3  binary index of the granted requester, registered. Valid only when `gnt_valid`=1, otherwise 0.
- `gnt_valid`  output  1  high while any grant is active; equals OR of `gnt`.
- `timeout`  output  1  one-cycle pulse when a grant is forcibly revoked by the `MAX_HOLD` timeout.

## Operation
- State machine has two states: IDLE and GRANT.
- Reset state:
  - state = IDLE
  - `gnt` = 8'h00, `gnt_id` = 3'd0, `gnt_valid` = 0, `timeout` = 0
  - priority pointer `last_id` = 3'd7
  - `hold_cnt` = 0
- IDLE:
  - If `req` = 0, stay in IDLE.
  - Otherwise the winner is the first set bit of `req` searching upward from `last_id`+1 (mod 8), wrapping 7→0.
  - At the edge: register `gnt` = 1<<winner, `gnt_id` = winner, `gnt_valid` = 1, `hold_cnt` = 0, go to GRANT.
- GRANT:
  - Release: if `req[gnt_id]` = 0 at an edge, then clear `gnt`/`gnt_id`/`gnt_valid`, set `last_id` = `gnt_id`, go to IDLE.
  - Timeout: if `MAX_HOLD` ≠ 0 and `hold_cnt` = `MAX_HOLD`−1 while `req[gnt_id]` = 1, then at the edge clear the grant, set `last_id` = `gnt_id`, assert `timeout` for exactly one cycle, go to IDLE.
  - Otherwise hold the grant and increment `hold_cnt` (8-bit, saturating at 255).
  - If release and timeout conditions coincide, release wins and `timeout` stays 0.
- Other requesters' bits are ignored while in GRANT. New requests and drops elsewhere have no effect.
- The revoked requester keeps `req` high to re-enter arbitration. Because `last_id` advanced past it, it gets lowest priority next round.
- `gnt` is always one-hot or zero, and `gnt_id` always matches the set bit of `gnt`.

## Timing
- Grant latency: `req` sampled in IDLE at edge N produces `gnt` visible after edge N (1 cycle, registered).
- Release latency: `req[gnt_id]` sampled low at edge M means `gnt` is 0 after edge M.
- Minimum gap between successive grants is one IDLE cycle. Back-to-back throughput is one grant per (hold + 1) cycles.
- With a timeout, `gnt` stays high exactly `MAX_HOLD` cycles, and the `timeout` pulse coincides with the first cycle of `gnt` = 0.
- Asynchronous reset asserted mid-grant clears all outputs immediately, independent of `clk`. After deassertion, the first arbitration starts from `last_id` = 7, so requester 0 has highest priority.
- `req` must be synchronous to `clk`. No combinational path from `req` to any output.

## Test plan
- Reset/priority:
  - Stimulus: hold `rst_n` = 0, then release with `req` = 8'hFF.
  - Required: outputs 0 during reset; first grant is `gnt` = 8'h01, `gnt_id` = 0 one cycle later.
- Rotation:
  - Stimulus: `req` = 8'hFF; each holder drops its bit for one cycle after 2 grant cycles, then re-raises it.
  - Required: grants go to ids 0,1,2,…,7,0 in order, with one IDLE cycle between grants.
- Wrap and skip:
  - Stimulus: `last_id` = 5 (requester 5 just released), `req` = 8'b0000_1001.
  - Required: grant to id 0 (8'h01), then, with 0 dropped, id 3 (8'h08).
- Hold and ignore:
  - Stimulus: grant id 2 and keep `req[2]` = 1 for 10 cycles with `MAX_HOLD` = 16, toggling `req[6]` meanwhile.
  - Required: `gnt` stays 8'h04 for all 10 cycles; `timeout` = 0.
- Timeout:
  - Stimulus: `MAX_HOLD` = 4; `req` = 8'b0001_0001 held constant.
  - Required: id 0 granted for exactly 4 cycles, `timeout` pulses one cycle, then id 4 granted. Grants then alternate 0/4 every 5 cycles.
- Reset mid-grant:
  - Stimulus: assert `rst_n` = 0 between clock edges while `gnt` = 8'h10.
  - Required: `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0 immediately. After release with `req` = 8'h10, grant to id 4 after one cycle.
